// File: rtl/nes_pkg.sv
// ----------------------------------------------------------------------------
// nes_pkg
// Types and constants shared by the NES bus masters and the bus decoder.
//   dma_state_t : OAM DMA sequencer states
//   bus_req_t   : one bus request (address, write data, direction 1 = read)
//   *_DEFAULT   : default register addresses and transfer length
//   is_reg_write: true when a CPU access is a write to a given register
// No ports (package).
// ----------------------------------------------------------------------------
package nes_pkg;

    localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;
    localparam int          XFER_LEN_DEFAULT      = 256;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        rw;
    } bus_req_t;

    function automatic logic is_reg_write(input logic [15:0] addr,
                                          input logic        rw,
                                          input logic [15:0] reg_addr);
        return (rw == 1'b0) && (addr == reg_addr);
    endfunction

endpackage

// File: rtl/cpu_cycle_parity.sv
// ----------------------------------------------------------------------------
// cpu_cycle_parity
// One-bit get/put cycle tracker: toggles on every clock after reset.
// Only built when OAM_DMA_ALIGN_EN is defined; without that macro the DMA
// never needs alignment and this module does not exist in the design.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  asynchronous, active-high; parity returns to 0
//   parity out 1  current cycle parity (0 = even)
// ----------------------------------------------------------------------------
`ifdef OAM_DMA_ALIGN_EN
module cpu_cycle_parity (
    input  logic clk,
    input  logic reset,
    output logic parity
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end

endmodule
`endif

// File: rtl/oam_dma_arbiter.sv
// ----------------------------------------------------------------------------
// oam_dma_arbiter
// NES sprite DMA sequencer. A CPU write to DMA_REG_ADDR halts the CPU, takes
// the system bus and copies page {data,00..FF} into OAM_DATA_ADDR, one
// read/write pair per byte. Outside a transfer the CPU drives the bus directly.
//
// Build option: OAM_DMA_ALIGN_EN
//   defined   : a transfer whose HALT cycle falls on odd parity inserts one
//               extra dummy read (ALIGN) -> 514 halted cycles instead of 513.
//   undefined : no ALIGN, no parity tracker, always 513 halted cycles.
//
// Ports:
//   clk        in  1   system clock, one CPU cycle per posedge
//   reset      in  1   asynchronous, active-high; back to IDLE
//   cpu_addr   in  16  CPU address
//   cpu_wdata  in  8   CPU write data
//   cpu_rw     in  1   CPU direction, 1 = read
//   bus_rdata  in  8   read data from the bus decoder
//   cpu_halt   out 1   CPU must hold its state this cycle
//   bus_addr   out 16  address to the bus decoder
//   bus_wdata  out 8   write data to the bus decoder
//   bus_rw     out 1   direction to the bus decoder, 1 = read
//   dma_active out 1   DMA owns the bus
// ----------------------------------------------------------------------------
module oam_dma_arbiter
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT,
    parameter int          XFER_LEN      = XFER_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_rdata,
    output logic        cpu_halt,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rw,
    output logic        dma_active
);

    localparam int               IDX_W    = $clog2(XFER_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    dma_state_t       state;
    dma_state_t       state_next;
    logic [7:0]       page;
    logic [IDX_W-1:0] index;
    logic [7:0]       data_buf;
    logic             trigger;
    bus_req_t         req;
    logic             halt;

    assign trigger = is_reg_write(cpu_addr, cpu_rw, DMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
    logic parity;

    cpu_cycle_parity u_parity (
        .clk    (clk),
        .reset  (reset),
        .parity (parity)
    );
`endif

    // State register plus the transfer datapath (page, index, byte buffer).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            page     <= 8'h00;
            index    <= '0;
            data_buf <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page  <= cpu_wdata;
                        index <= '0;
                    end
                end
                READ: begin
                    data_buf <= bus_rdata;
                end
                WRITE: begin
                    // Index stops at the last byte; it never carries into page.
                    if (index != LAST_IDX) begin
                        index <= index + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = HALT;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                // Odd cycle: burn one more dummy read so reads land on get cycles.
                state_next = parity ? ALIGN : READ;
`else
                state_next = READ;
`endif
            end
            ALIGN: begin
                state_next = READ;
            end
            READ: begin
                state_next = WRITE;
            end
            WRITE: begin
                state_next = (index == LAST_IDX) ? IDLE : READ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: bus mux and halt, decoded from the current state only, so
    // an asynchronous reset releases the bus in the same cycle.
    always_comb begin
        req  = '{addr: cpu_addr, wdata: cpu_wdata, rw: cpu_rw};
        halt = 1'b0;
        case (state)
            IDLE: begin
            end
            HALT, ALIGN: begin
                // Dummy read at whatever address the halted CPU is presenting.
                halt = 1'b1;
                req  = '{addr: cpu_addr, wdata: 8'h00, rw: 1'b1};
            end
            READ: begin
                halt = 1'b1;
                req  = '{addr: {page, 8'h00} | 16'(index), wdata: 8'h00, rw: 1'b1};
            end
            WRITE: begin
                halt = 1'b1;
                req  = '{addr: OAM_DATA_ADDR, wdata: data_buf, rw: 1'b0};
            end
            default: begin
            end
        endcase
    end

    assign bus_addr   = req.addr;
    assign bus_wdata  = req.wdata;
    assign bus_rw     = req.rw;
    assign cpu_halt   = halt;
    assign dma_active = halt;

endmodule
